// File: rtl/car_frame_sched_pkg.sv
// Shared types and helpers for the car frame scheduler.
// Holds FSM encodings, the frame record layout and a saturating counter step.
package car_sched_pkg;

    localparam int CAR_WIDTH = 8;
    localparam int CAR_DEPTH = 6;
    localparam int REC_W     = CAR_DEPTH + 2 * CAR_WIDTH;
    localparam logic [7:0] HDR_DEF = 8'hAA;

    typedef enum logic [2:0] {
        P_HDR,
        P_ID,
        P_X,
        P_Y,
        P_CHK
    } parse_t;

    typedef enum logic [2:0] {
        I_IDLE,
        I_ID,
        I_X,
        I_Y,
        I_WAIT
    } issue_t;

    typedef struct packed {
        logic [CAR_DEPTH-1:0] id;
        logic [CAR_WIDTH-1:0] x;
        logic [CAR_WIDTH-1:0] y;
    } rec_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/car_frame_sched_if.sv
// Bundle of the UART-side inputs and datapath/status outputs of car_frame_sched.
// master: the environment driving rx/enable; slave: the scheduler itself.
interface car_frame_sched_if #(
    parameter int width      = 8,
    parameter int depth      = 6,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [width-1:0] i_rx_data;
    logic             i_rx_done;
    logic             i_enable;
    logic             o_start;
    logic [width-1:0] o_car;
    logic             o_busy;
    logic [LW-1:0]    o_fifo_level;
    logic [7:0]       o_err_chk;
    logic [7:0]       o_err_timeout;
    logic [7:0]       o_drop;
    logic [depth-1:0] o_last_id;

    modport master (
        output i_rx_data, i_rx_done, i_enable,
        input  o_start, o_car, o_busy, o_fifo_level,
        input  o_err_chk, o_err_timeout, o_drop, o_last_id
    );

    modport slave (
        input  i_rx_data, i_rx_done, i_enable,
        output o_start, o_car, o_busy, o_fifo_level,
        output o_err_chk, o_err_timeout, o_drop, o_last_id
    );

endinterface

// File: rtl/car_frame_sched_fifo.sv
// Synchronous show-ahead FIFO for parsed frame records.
// Ports: clk/rst, i_push/i_din, i_pop/o_dout, o_full, o_empty, o_level.
module car_frame_fifo #(
    parameter int W = 22,
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [W-1:0]       i_din,
    input  logic               i_pop,
    output logic [W-1:0]       o_dout,
    output logic               o_full,
    output logic               o_empty,
    output logic [$clog2(N):0] o_level
);
    localparam int AW = $clog2(N);

    logic [W-1:0]  r_mem [N];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_rd;
    logic          w_wr;

    assign o_full  = (r_cnt == (AW+1)'(N));
    assign o_empty = (r_cnt == '0);
    assign o_level = r_cnt;
    assign o_dout  = r_mem[r_rp];

    // A push into a full FIFO still lands if the head leaves this cycle.
    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd) begin
                r_rp <= r_rp + 1'b1;
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/car_frame_sched.sv
// Parses framed car records from a UART byte stream and issues them to the speed datapath.
// Ports: clk, rst (sync, active-high), bus (rx/enable in; start/car/busy/level/errors/last_id out).
module car_frame_sched
    import car_sched_pkg::*;
#(
    parameter int               width      = CAR_WIDTH,
    parameter int               depth      = CAR_DEPTH,
    parameter int               FIFO_DEPTH = 4,
    parameter int               TIMEOUT    = 20000,
    parameter int               SPEED_LAT  = 8,
    parameter logic [width-1:0] HDR        = HDR_DEF
) (
    input logic               clk,
    input logic               rst,
    car_frame_sched_if.slave  bus
);
    localparam int W_REC = depth + 2 * width;
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int GW    = $clog2(TIMEOUT + 1);
    localparam int CW    = $clog2(SPEED_LAT + 1);

    parse_t           r_pst;
    parse_t           w_pst_nxt;
    logic [width-1:0] r_id;
    logic [width-1:0] r_x;
    logic [width-1:0] r_y;
    logic [GW-1:0]    r_gap;
    logic [7:0]       r_err_chk;
    logic [7:0]       r_err_tmo;
    logic [7:0]       r_drop;
    logic             w_rx;
    logic [width-1:0] w_byte;
    logic             w_tmo;
    logic             w_good;
    logic             w_frame;
    logic             w_push;
    logic             w_bad;

    issue_t           r_ist;
    issue_t           w_ist_nxt;
    logic [CW-1:0]    r_wcnt;
    logic [width-1:0] r_rec_x;
    logic [width-1:0] r_rec_y;
    logic [width-1:0] r_car;
    logic [width-1:0] w_car_nxt;
    logic             r_start;
    logic             r_busy;
    logic [depth-1:0] r_last_id;
    logic             w_pop;

    logic [W_REC-1:0] w_head;
    logic [depth-1:0] w_head_id;
    logic             w_full;
    logic             w_empty;
    logic [LW-1:0]    w_level;

    assign w_rx   = bus.i_rx_done;
    assign w_byte = bus.i_rx_data;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_tmo   = (r_pst != P_HDR) && !w_rx
                     && (r_gap == GW'(TIMEOUT - 1));
    assign w_good  = (w_byte == (r_id ^ r_x ^ r_y))
                     && ((r_id >> depth) == '0);
    assign w_frame = w_rx && (r_pst == P_CHK);
    assign w_push  = w_frame && w_good;
    assign w_bad   = w_frame && !w_good;

    always_comb begin
        w_pst_nxt = r_pst;
        if (w_tmo) begin
            w_pst_nxt = P_HDR;
        end else if (w_rx) begin
            unique case (r_pst)
                P_HDR:   w_pst_nxt = (w_byte == HDR) ? P_ID : P_HDR;
                P_ID:    w_pst_nxt = P_X;
                P_X:     w_pst_nxt = P_Y;
                P_Y:     w_pst_nxt = P_CHK;
                P_CHK:   w_pst_nxt = P_HDR;
                default: w_pst_nxt = P_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pst     <= P_HDR;
            r_gap     <= '0;
            r_id      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_err_chk <= '0;
            r_err_tmo <= '0;
        end else begin
            r_pst <= w_pst_nxt;
            if (w_rx || w_tmo || (r_pst == P_HDR)) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + 1'b1;
            end
            if (w_rx && (r_pst == P_ID)) begin
                r_id <= w_byte;
            end
            if (w_rx && (r_pst == P_X)) begin
                r_x <= w_byte;
            end
            if (w_rx && (r_pst == P_Y)) begin
                r_y <= w_byte;
            end
            if (w_bad) begin
                r_err_chk <= sat_inc(r_err_chk);
            end
            if (w_tmo) begin
                r_err_tmo <= sat_inc(r_err_tmo);
            end
        end
    end

    car_frame_fifo #(
        .W (W_REC),
        .N (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({r_id[depth-1:0], r_x, r_y}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign w_head_id = w_head[W_REC-1 -: depth];
    assign w_pop     = (r_ist == I_IDLE) && !w_empty && bus.i_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= '0;
        end else if (w_push && w_full && !w_pop) begin
            r_drop <= sat_inc(r_drop);
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        w_ist_nxt = r_ist;
        w_car_nxt = '0;
        unique case (r_ist)
            I_IDLE:  w_ist_nxt = w_pop ? I_ID : I_IDLE;
            I_ID:    w_ist_nxt = I_X;
            I_X:     w_ist_nxt = I_Y;
            I_Y:     w_ist_nxt = I_WAIT;
            I_WAIT:  w_ist_nxt = (r_wcnt == CW'(SPEED_LAT - 1))
                                 ? I_IDLE : I_WAIT;
            default: w_ist_nxt = I_IDLE;
        endcase
        unique case (w_ist_nxt)
            I_ID:    w_car_nxt = width'(w_head_id);
            I_X:     w_car_nxt = r_rec_x;
            I_Y:     w_car_nxt = r_rec_y;
            default: w_car_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ist     <= I_IDLE;
            r_wcnt    <= '0;
            r_rec_x   <= '0;
            r_rec_y   <= '0;
            r_car     <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_last_id <= '0;
        end else begin
            r_ist   <= w_ist_nxt;
            r_car   <= w_car_nxt;
            r_start <= (w_ist_nxt == I_ID);
            r_busy  <= (w_ist_nxt != I_IDLE);
            r_wcnt  <= (r_ist == I_WAIT) ? r_wcnt + 1'b1 : '0;
            if (w_pop) begin
                r_rec_x   <= w_head[2*width-1 -: width];
                r_rec_y   <= w_head[width-1:0];
                r_last_id <= w_head_id;
            end
        end
    end

    assign bus.o_start       = r_start;
    assign bus.o_car         = r_car;
    assign bus.o_busy        = r_busy;
    assign bus.o_fifo_level  = w_level;
    assign bus.o_err_chk     = r_err_chk;
    assign bus.o_err_timeout = r_err_tmo;
    assign bus.o_drop        = r_drop;
    assign bus.o_last_id     = r_last_id;

endmodule

// File: tb/tb_car_frame_sched.sv
// Directed self-checking bench for car_frame_sched.
// Drives framed UART bytes and checks bursts, counters, FIFO and reset.
module tb_car_frame_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    car_frame_sched_if ifc ();

    car_frame_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int ph     = 0;
    int q_t[$];
    logic [7:0] q_id[$];
    logic [7:0] q_x[$];
    logic [7:0] q_y[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifc.o_start) begin
            q_t.push_back(cyc);
            q_id.push_back(ifc.o_car);
            ph = 1;
        end else if (ph == 1) begin
            q_x.push_back(ifc.o_car);
            ph = 2;
        end else if (ph == 2) begin
            q_y.push_back(ifc.o_car);
            ph = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        ifc.i_rx_data = b;
        ifc.i_rx_done = 1'b1;
        tick(1);
        ifc.i_rx_done = 1'b0;
    endtask

    task automatic frame(input logic [7:0] id, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] c);
        send(8'hAA);
        send(id);
        send(x);
        send(y);
        send(c);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, ifc.o_start, 0);
        check({tag, "_car"}, ifc.o_car, 0);
        check({tag, "_busy"}, ifc.o_busy, 0);
        check({tag, "_level"}, ifc.o_fifo_level, 0);
        check({tag, "_echk"}, ifc.o_err_chk, 0);
        check({tag, "_etmo"}, ifc.o_err_timeout, 0);
        check({tag, "_drop"}, ifc.o_drop, 0);
        check({tag, "_lastid"}, ifc.o_last_id, 0);
    endtask

    int n0;
    logic [7:0] v;

    initial begin
        rst           = 1'b1;
        ifc.i_rx_data = '0;
        ifc.i_rx_done = 1'b0;
        ifc.i_enable  = 1'b1;
        tick(3);
        check_all_zero("rst");
        rst = 1'b0;
        tick(2);

        frame(8'h05, 8'h10, 8'h20, 8'h35);
        tick(1);
        check("t1_start", ifc.o_start, 1);
        check("t1_car_id", ifc.o_car, 8'h05);
        check("t1_lastid", ifc.o_last_id, 5);
        check("t1_busy_id", ifc.o_busy, 1);
        tick(1);
        check("t1_start_lo", ifc.o_start, 0);
        check("t1_car_x", ifc.o_car, 8'h10);
        tick(1);
        check("t1_car_y", ifc.o_car, 8'h20);
        tick(1);
        check("t1_car_wait", ifc.o_car, 0);
        check("t1_busy_wait", ifc.o_busy, 1);
        tick(7);
        check("t1_busy_last", ifc.o_busy, 1);
        tick(1);
        check("t1_busy_done", ifc.o_busy, 0);
        tick(4);

        n0 = q_t.size();
        frame(8'h05, 8'h10, 8'h20, 8'h00);
        tick(20);
        check("t2_echk1", ifc.o_err_chk, 1);
        check("t2_nostart1", q_t.size(), n0);
        frame(8'h45, 8'h10, 8'h20, 8'h75);
        tick(20);
        check("t2_echk2", ifc.o_err_chk, 2);
        check("t2_nostart2", q_t.size(), n0);
        check("t2_level", ifc.o_fifo_level, 0);

        send(8'hAA);
        send(8'h07);
        send(8'h11);
        tick(19990);
        check("t3_tmo_early", ifc.o_err_timeout, 0);
        tick(15);
        check("t3_tmo", ifc.o_err_timeout, 1);
        check("t3_echk", ifc.o_err_chk, 2);
        frame(8'h03, 8'h04, 8'h05, 8'h02);
        tick(1);
        check("t3_start", ifc.o_start, 1);
        check("t3_car", ifc.o_car, 8'h03);
        tick(14);

        ifc.i_enable = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            v = 8'(i);
            frame(v, v + 8'h20, v + 8'h40, v ^ (v + 8'h20) ^ (v + 8'h40));
        end
        tick(2);
        check("t4_level", ifc.o_fifo_level, 4);
        check("t4_drop", ifc.o_drop, 2);
        check("t4_busy", ifc.o_busy, 0);
        n0 = q_t.size();
        ifc.i_enable = 1'b1;
        tick(60);
        check("t4_nbursts", q_t.size() - n0, 4);
        if (q_t.size() - n0 == 4) begin
            for (int k = 0; k < 4; k++) begin
                v = 8'(k + 1);
                check($sformatf("t4_id%0d", k), q_id[n0+k], v);
                check($sformatf("t4_x%0d", k), q_x[n0+k], v + 8'h20);
                check($sformatf("t4_y%0d", k), q_y[n0+k], v + 8'h40);
                if (k > 0)
                    check($sformatf("t4_gap%0d", k),
                          q_t[n0+k] - q_t[n0+k-1], 12);
            end
        end
        check("t4_lastid", ifc.o_last_id, 4);
        check("t4_level0", ifc.o_fifo_level, 0);

        send(8'h00);
        send(8'hFF);
        send(8'hAB);
        frame(8'h09, 8'h01, 8'h02, 8'h0A);
        tick(1);
        check("t5_start", ifc.o_start, 1);
        check("t5_car_id", ifc.o_car, 8'h09);
        tick(1);
        check("t5_car_x", ifc.o_car, 8'h01);
        rst = 1'b1;
        tick(1);
        check_all_zero("t5_rst");
        rst = 1'b0;
        n0 = q_t.size();
        tick(20);
        check("t5_nostart", q_t.size(), n0);

        for (int i = 0; i < 254; i++) frame(8'h01, 8'h02, 8'h03, 8'hFF);
        tick(1);
        check("t6_echk254", ifc.o_err_chk, 254);
        for (int i = 0; i < 6; i++) frame(8'h01, 8'h02, 8'h03, 8'hFF);
        tick(1);
        check("t6_echk_sat", ifc.o_err_chk, 255);
        check("t6_nostart", q_t.size(), n0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/car_frame_sched.md
Name: car_frame_sched

Overview:
- Front-end controller for the speed datapath.
- Parses framed car records arriving as a UART byte stream (header, id, x, y, checksum) and buffers valid records in a small frame FIFO.
- Sequences each record into the datapath as a start pulse followed by a three-byte burst on the car bus, then holds off for the datapath's processing latency.
- Sits between the UART receiver and the speed datapath's start/car inputs.

Parameters:
- width, 8, byte width of rx data and car bus
- depth, 6, id address width; valid ids are 0..2**depth-1
- FIFO_DEPTH, 4, frame FIFO entries (power of two)
- TIMEOUT, 20000, max clk cycles between bytes within a frame
- SPEED_LAT, 8, hold-off cycles after a burst before the next issue
- HDR, 8'hAA, frame header byte

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_rx_data  in  width  received UART byte
- i_rx_done  in  1  one-cycle strobe, i_rx_data valid
- i_enable  in  1  permits issue of new frames to the datapath
- o_start  out  1  one-cycle start pulse to the speed datapath
- o_car  out  width  car byte bus to the speed datapath
- o_busy  out  1  issue FSM not idle
- o_fifo_level  out  clog2(FIFO_DEPTH)+1  frames buffered
- o_err_chk  out  8  saturating count of checksum/id-range errors
- o_err_timeout  out  8  saturating count of inter-byte timeouts
- o_drop  out  8  saturating count of valid frames dropped, FIFO full
- o_last_id  out  depth  id of the most recently issued frame

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - all outputs 0
  - parse FSM = P_HDR, issue FSM = I_IDLE
  - FIFO empty, counters 0
- Reset mid-frame or mid-burst aborts everything; no partial burst continues.
- Parse FSM advances only on i_rx_done: P_HDR -> P_ID -> P_X -> P_Y -> P_CHK -> P_HDR.
  - P_HDR: bytes other than HDR are ignored; the FSM stays in P_HDR.
  - P_ID, P_X, P_Y: latch the byte.
  - P_CHK: the frame is good iff byte == id^x^y and id < 2**depth.
    - Good frame: push {id[depth-1:0], x, y}.
    - Bad frame: o_err_chk++ (saturates at 255), nothing pushed.
- Timeout:
  - The gap counter clears on every i_rx_done and counts while the parse state is not P_HDR.
  - On reaching TIMEOUT: parse returns to P_HDR, o_err_timeout++ (saturating), partial frame discarded.
  - If i_rx_done coincides with the timeout cycle, the byte wins and the timeout is ignored.
- FIFO:
  - A push while full drops the frame and increments o_drop (saturating).
  - A push and pop in the same cycle while full is accepted and the level is unchanged.
  - o_fifo_level is the registered count.
- Issue FSM, states I_IDLE, I_ID, I_X, I_Y, I_WAIT:
  - I_IDLE: if FIFO not empty and i_enable, pop and go to I_ID next cycle.
  - I_ID: o_start=1, o_car=id zero-extended to width, o_last_id updated.
  - I_X: o_car=x.
  - I_Y: o_car=y.
  - I_WAIT: count SPEED_LAT cycles, then I_IDLE.
- Issue timing and outputs:
  - o_car=0 in I_IDLE and I_WAIT. o_start is high only in I_ID.
  - Latency: the earliest o_start is 2 cycles after the i_rx_done carrying a good checksum (push cycle, then pop cycle).
  - Minimum frame spacing is 3+SPEED_LAT+1 cycles, start to start.
  - o_busy=1 in every state except I_IDLE.
- Deasserting i_enable never truncates a burst or wait; it only blocks the next pop.
- All outputs are registered.

Decomposition:
- Package car_sched_pkg:
  - parse and issue state encodings
  - frame record struct/width constant (depth+2*width)
  - HDR default
  - saturating-increment helper function
- One sub-module: car_frame_fifo, a synchronous FIFO with width/depth params, push, pop, full, empty and level.
- Parse and issue FSMs stay in the top.

Test Plan:
- Send AA,05,10,20,35 with i_enable=1 -> o_start 1 cycle with o_car=05, then o_car=10, then o_car=20; o_last_id=5; o_busy high for 3+8 cycles.
- Send AA,05,10,20,00 (bad checksum) -> no o_start; o_err_chk=1. Then AA,45,...,correct xor (id 0x45 ≥ 64) -> o_err_chk=2.
- Send AA,07,11, then idle 20000 cycles -> o_err_timeout=1, parse back in P_HDR; a following good frame issues normally.
- i_enable=0, send 6 good frames -> o_fifo_level=4, o_drop=2. Then i_enable=1 -> 4 bursts in order, spaced exactly 12 cycles start-to-start.
- Garbage bytes 00,FF,AB before AA frame -> ignored, frame issues; pulse rst during I_X -> next cycle o_car=0, o_start=0, level=0, counters=0.
- Force 256+ checksum errors -> o_err_chk holds at 255.
